// File: rtl/mcs6530_bus_master.sv
// mcs6530_bus_master
// ------------------
// CPU-side bus initiator for the mcs6530 RRIOT core. It generates the
// free-running phi2 clock from phi2_2x and turns a valid/ready request stream
// into phi2-aligned 6502 bus cycles. Each bus cycle lasts one phi2 period:
// a low phase followed by a high phase. A read captures the core's data at
// the end of the high phase. Every accepted request returns exactly one
// single-clock response pulse.
//
// Optional feature (macro MCS6530_BUS_MASTER_RDY_EN):
//   When defined, read cycles honour the active-low rdy wait-state input.
//   A read that is stalled for RDY_TIMEOUT phi2 periods is aborted with an
//   error. When undefined, rdy is ignored and every cycle takes 2 clocks.
//
// Ports:
//   phi2_2x    clock at twice the phi2 rate
//   rst        synchronous, active-high reset
//   req_*      request stream: valid/ready handshake, we, addr, rs0, cs1, wdata
//   rsp_*      response: valid pulse, read data, error flag
//   phi2       generated phase-2 clock to the core
//   bus_*      core bus: addr, rs0, cs1, r_w (1 = read), do (write data),
//              di (read data), oe (core is driving di)
//   rdy        wait-state request, low = stall (used only with the feature)

module mcs6530_bus_master #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RDY_TIMEOUT = 255
) (
  input  logic              phi2_2x,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_rs0,
  input  logic              req_cs1,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic              phi2,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rs0,
  output logic              bus_cs1,
  output logic              bus_r_w,
  output logic [DATA_W-1:0] bus_do,
  input  logic [DATA_W-1:0] bus_di,
  input  logic              bus_oe,

  input  logic              rdy
);

  // Bus cycle sequencer states. LOW always coincides with phi2 = 0 and HIGH
  // with phi2 = 1, because a cycle can only start at a phi2 1->0 edge.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;

  logic accept;    // request taken on this edge
  logic stall;     // high phase ends without completing (wait state)
  logic abort;     // high phase ends a read that has timed out
  logic complete;  // the current bus cycle finishes on this edge

`ifdef MCS6530_BUS_MASTER_RDY_EN
  localparam int unsigned CntW = (RDY_TIMEOUT > 0) ? $clog2(RDY_TIMEOUT + 1) : 1;

  logic [CntW-1:0] wait_cnt;
  logic            rdy_low_read;
  logic            timed_out;

  // bus_r_w is the registered direction of the cycle in flight; writes never
  // wait, matching 6502 behaviour where RDY only stretches reads.
  assign rdy_low_read = (state == StHigh) && bus_r_w && !rdy;
  assign timed_out    = (wait_cnt == CntW'(RDY_TIMEOUT));
  assign stall        = rdy_low_read && !timed_out;
  assign abort        = rdy_low_read && timed_out;

  // Counts stalled phi2 periods of the current transaction only.
  always_ff @(posedge phi2_2x) begin
    if (rst || accept) begin
      wait_cnt <= '0;
    end else if (stall) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_rdy;

  assign unused_rdy = rdy;
  assign stall      = 1'b0;
  assign abort      = 1'b0;
`endif

  // A new request may be accepted only at the phi2 1->0 edge, either from
  // idle or overlapping the completion of the previous cycle.
  assign req_ready = !rst && phi2 && ((state == StIdle) || ((state == StHigh) && !stall));
  assign accept    = req_valid && req_ready;
  assign complete  = (state == StHigh) && !stall;

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle: begin
        if (accept) begin
          state_next = StLow;
        end
      end
      StLow: begin
        state_next = StHigh;
      end
      StHigh: begin
        if (stall || accept) begin
          state_next = StLow;
        end else begin
          state_next = StIdle;
        end
      end
      default: begin
        state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge phi2_2x) begin
    if (rst) begin
      // An in-flight cycle is dropped silently.
      state     <= StIdle;
      phi2      <= 1'b0;
      bus_addr  <= '0;
      bus_rs0   <= 1'b0;
      bus_cs1   <= 1'b0;
      bus_r_w   <= 1'b1;
      bus_do    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      phi2      <= ~phi2;
      rsp_valid <= complete;

      if (complete) begin
        if (bus_r_w) begin
          if (abort) begin
            // Timed-out read: report the error, keep the old data.
            rsp_err <= 1'b1;
          end else begin
            rsp_rdata <= bus_di;
            rsp_err   <= !bus_oe;
          end
        end else begin
          rsp_err <= 1'b0;
        end
      end

      // Bus outputs move only at an acceptance edge, or drop back to the
      // idle read/deselected level when the last cycle finishes.
      if (accept) begin
        bus_addr <= req_addr;
        bus_rs0  <= req_rs0;
        bus_cs1  <= req_cs1;
        bus_r_w  <= !req_we;
        if (req_we) begin
          bus_do <= req_wdata;
        end
      end else if (complete) begin
        bus_r_w <= 1'b1;
        bus_cs1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcs6530_bus_master.sv
module tb_mcs6530_bus_master;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int RDY_TO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_rs0 = 1'b0;
  logic              req_cs1 = 1'b0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              phi2;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rs0;
  logic              bus_cs1;
  logic              bus_r_w;
  logic [DATA_W-1:0] bus_do;
  logic [DATA_W-1:0] bus_di;
  logic              bus_oe;
  logic              rdy_in = 1'b1;

  mcs6530_bus_master #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RDY_TIMEOUT(RDY_TO)
  ) dut (
    .phi2_2x  (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_rs0  (req_rs0),
    .req_cs1  (req_cs1),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .phi2     (phi2),
    .bus_addr (bus_addr),
    .bus_rs0  (bus_rs0),
    .bus_cs1  (bus_cs1),
    .bus_r_w  (bus_r_w),
    .bus_do   (bus_do),
    .bus_di   (bus_di),
    .bus_oe   (bus_oe),
    .rdy      (rdy_in)
  );

  always #5 clk = ~clk;

  // Stand-in core: RAM that is written at the end of a selected write cycle
  // and drives its data while selected in a read cycle; open bus reads 0xFF.
  logic [DATA_W-1:0] core_mem [1024];
  bit                core_loaded = 1'b0;

  always @(posedge clk) begin
    if (!core_loaded) begin
      for (int i = 0; i < 1024; i++) core_mem[i] <= DATA_W'(i * 37 + 5);
      core_loaded <= 1'b1;
    end else if (phi2 && !bus_r_w && bus_cs1) begin
      core_mem[bus_addr] <= bus_do;
    end
  end

  assign bus_di = bus_cs1 ? core_mem[bus_addr] : 8'hFF;
  assign bus_oe = bus_cs1 & bus_r_w;

  // Reference model: memory image, last returned read data, expected responses.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    int unsigned       cyc;
  } rsp_t;

  logic [DATA_W-1:0] ref_mem [1024];
  logic [DATA_W-1:0] last_rdata = '0;
  rsp_t              exp_q[$];
  rsp_t              obs_q[$];

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned ready_miss = 0;
  bit          watch_ready = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) obs_q.push_back('{data: rsp_rdata, err: rsp_err, cyc: cyc});
    if (watch_ready && phi2 === 1'b1 && req_ready !== 1'b1) ready_miss++;
  end

  // Expected response of one transaction, from the bus rules alone.
  function automatic void model_push(input logic we, input logic [ADDR_W-1:0] addr,
                                     input logic cs1, input logic [DATA_W-1:0] wd,
                                     input bit timeout, input int unsigned c);
    rsp_t e;
    e.cyc = c;
    if (we) begin
      if (cs1) ref_mem[addr] = wd;
      e.data = last_rdata;
      e.err  = 1'b0;
    end else if (timeout) begin
      e.data = last_rdata;
      e.err  = 1'b1;
    end else begin
      e.data     = cs1 ? ref_mem[addr] : 8'hFF;
      e.err      = !cs1;
      last_rdata = e.data;
    end
    exp_q.push_back(e);
  endfunction

  task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic rs0,
                      input logic cs1, input logic [DATA_W-1:0] wd, input bit timeout);
    bit done = 1'b0;
    req_we    = we;
    req_addr  = addr;
    req_rs0   = rs0;
    req_cs1   = cs1;
    req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        acc_cyc = cyc;
        model_push(we, addr, cs1, wd, timeout, cyc);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_accept: request addr %h never accepted (ready=%b), expected acceptance",
               addr, req_ready);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_phi;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({phi2, req_ready, bus_r_w, rsp_valid, rsp_err, bus_cs1, bus_rs0} !== 7'b0010000) begin
      failures++;
      $display("FAIL reset_ctrl: phi2/ready/r_w/rsp_valid/err/cs1/rs0 = %b, expected 0010000",
               {phi2, req_ready, bus_r_w, rsp_valid, rsp_err, bus_cs1, bus_rs0});
    end
    checks++;
    if ({bus_addr, bus_do, rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h do=%h rdata=%h, expected all zero",
               bus_addr, bus_do, rsp_rdata);
    end
    rst = 1'b0;
    exp_phi = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (phi2 !== exp_phi || req_ready !== exp_phi || bus_r_w !== 1'b1) begin
        failures++;
        $display("FAIL free_run[%0d]: phi2=%b ready=%b r_w=%b, expected phi2=%b ready=%b r_w=1",
                 i, phi2, req_ready, bus_r_w, exp_phi, exp_phi);
      end
      @(posedge clk);
      #1;
      exp_phi = ~exp_phi;
    end
  endtask

  task automatic test_write_read();
    rsp_t o, e;
    send(1'b1, 10'h080, 1'b0, 1'b1, 8'hA5, 1'b0);
    checks++;
    if (bus_r_w !== 1'b0 || bus_addr !== 10'h080 || bus_do !== 8'hA5 || bus_cs1 !== 1'b1) begin
      failures++;
      $display("FAIL wr_bus: r_w=%b addr=%h do=%h cs1=%b, expected 0 080 a5 1",
               bus_r_w, bus_addr, bus_do, bus_cs1);
    end
    send(1'b0, 10'h080, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (bus_r_w !== 1'b1 || bus_addr !== 10'h080) begin
      failures++;
      $display("FAIL rd_bus: r_w=%b addr=%h, expected 1 080", bus_r_w, bus_addr);
    end
    idle(6);
    checks++;
    if (obs_q.size() != 2) begin
      failures++;
      $display("FAIL wr_rd_count: %0d responses, expected 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[1].cyc - obs_q[0].cyc != 2 || obs_q[1].data !== 8'hA5 || obs_q[1].err !== 1'b0) begin
        failures++;
        $display("FAIL wr_rd_rsp: gap=%0d data=%h err=%b, expected gap=2 data=a5 err=0",
                 obs_q[1].cyc - obs_q[0].cyc, obs_q[1].data, obs_q[1].err);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o.data !== e.data || o.err !== e.err) begin
          failures++;
          $display("FAIL wr_rd_model: data=%h err=%b, expected data=%h err=%b",
                   o.data, o.err, e.data, e.err);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    rsp_t o, e;
    int unsigned first_acc;
    ready_miss  = 0;
    watch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, ADDR_W'($urandom_range(0, 1023)), 1'($urandom), 1'b1, 8'h00, 1'b0);
      if (i == 0) first_acc = acc_cyc;
    end
    idle(6);
    watch_ready = 1'b0;
    checks++;
    if (ready_miss != 0) begin
      failures++;
      $display("FAIL b2b_ready: ready low on %0d phi2=1 clocks, expected 0", ready_miss);
    end
    checks++;
    if (obs_q.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: %0d responses, expected 4", obs_q.size());
    end else begin
      // Accept at a phi2 1->0 edge; response visible just after the edge
      // that ends the high phase, i.e. one full phi2 period later.
      checks++;
      if (obs_q[0].cyc - first_acc != 3 || obs_q[3].cyc - obs_q[0].cyc != 6) begin
        failures++;
        $display("FAIL b2b_timing: first latency=%0d span=%0d, expected 3 and 6",
                 obs_q[0].cyc - first_acc, obs_q[3].cyc - obs_q[0].cyc);
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o.data !== e.data || o.err !== e.err) begin
          failures++;
          $display("FAIL b2b_data: data=%h err=%b, expected data=%h err=%b",
                   o.data, o.err, e.data, e.err);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_unmapped();
    send(1'b0, ADDR_W'($urandom_range(0, 1023)), 1'($urandom), 1'b0, 8'h00, 1'b0);
    idle(4);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 8'hFF || obs_q[0].err !== 1'b1) begin
      failures++;
      $display("FAIL unmapped: count=%0d data=%h err=%b, expected 1 ff 1",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 8'hxx,
               obs_q.size() > 0 ? obs_q[0].err : 1'bx);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    rsp_t o, e;
    int n_exp;
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom), ADDR_W'($urandom_range(0, 31)), 1'($urandom),
           1'($urandom_range(0, 7) != 0), DATA_W'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    checks++;
    if (bus_r_w !== 1'b1 || bus_cs1 !== 1'b0) begin
      failures++;
      $display("FAIL rand_idle_bus: r_w=%b cs1=%b, expected 1 0", bus_r_w, bus_cs1);
    end
    n_exp = exp_q.size();
    checks++;
    if (obs_q.size() != n_exp) begin
      failures++;
      $display("FAIL rand_count: %0d responses, expected %0d", obs_q.size(), n_exp);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.err !== e.err || o.cyc - e.cyc < 3) begin
        failures++;
        $display("FAIL rand_rsp: data=%h err=%b lat=%0d, expected data=%h err=%b lat>=3",
                 o.data, o.err, o.cyc - e.cyc, e.data, e.err);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    send(1'b0, 10'h011, 1'b1, 1'b1, 8'h00, 1'b0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    // Now in the high phase of the read.
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({phi2, req_ready, bus_r_w, rsp_valid, rsp_err, bus_cs1, bus_rs0} !== 7'b0010000 ||
        {bus_addr, bus_do, rsp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid_out: ctrl=%b addr=%h do=%h rdata=%h, expected 0010000 and zeros",
               {phi2, req_ready, bus_r_w, rsp_valid, rsp_err, bus_cs1, bus_rs0},
               bus_addr, bus_do, rsp_rdata);
    end
    rst = 1'b0;
    exp_q.delete();
    last_rdata = '0;
    idle(6);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_rsp: %0d responses, expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

`ifdef MCS6530_BUS_MASTER_RDY_EN
  task automatic test_rdy();
    int unsigned acc;
    // Stalled read: 3 wait periods then rdy high.
    send(1'b1, 10'h155, 1'b0, 1'b1, 8'h3C, 1'b0);
    idle(4);
    obs_q.delete();
    exp_q.delete();
    rdy_in = 1'b0;
    send(1'b0, 10'h155, 1'b0, 1'b1, 8'h00, 1'b0);
    acc = acc_cyc;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rdy_in = 1'b1;
    idle(6);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].cyc - acc != 9 || obs_q[0].data !== 8'h3C ||
        obs_q[0].err !== 1'b0) begin
      failures++;
      $display("FAIL rdy_wait: count=%0d lat=%0d data=%h err=%b, expected 1 9 3c 0",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].cyc - acc : 0,
               obs_q.size() > 0 ? obs_q[0].data : 8'hxx, obs_q.size() > 0 ? obs_q[0].err : 1'bx);
    end
    obs_q.delete();
    exp_q.delete();
    // Stuck rdy: read times out after RDY_TO stalled periods plus one.
    rdy_in = 1'b0;
    send(1'b0, 10'h200, 1'b0, 1'b1, 8'h00, 1'b1);
    acc = acc_cyc;
    idle(14);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].cyc - acc != 3 + 2 * RDY_TO || obs_q[0].data !== 8'h3C ||
        obs_q[0].err !== 1'b1) begin
      failures++;
      $display("FAIL rdy_timeout: count=%0d lat=%0d data=%h err=%b, expected 1 %0d 3c 1",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].cyc - acc : 0,
               obs_q.size() > 0 ? obs_q[0].data : 8'hxx,
               obs_q.size() > 0 ? obs_q[0].err : 1'bx, 3 + 2 * RDY_TO);
    end
    obs_q.delete();
    exp_q.delete();
    // Writes ignore rdy.
    send(1'b1, 10'h201, 1'b0, 1'b1, 8'h77, 1'b0);
    acc = acc_cyc;
    idle(4);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].cyc - acc != 3 || obs_q[0].err !== 1'b0) begin
      failures++;
      $display("FAIL rdy_write: count=%0d lat=%0d err=%b, expected 1 3 0",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].cyc - acc : 0,
               obs_q.size() > 0 ? obs_q[0].err : 1'bx);
    end
    rdy_in = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = DATA_W'(i * 37 + 5);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_unmapped();
    test_random();
    test_reset_mid();
`ifdef MCS6530_BUS_MASTER_RDY_EN
    test_rdy();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcs6530_bus_master.md
Name: mcs6530_bus_master

Overview:
- 6502-side bus initiator for the mcs6530 RRIOT core; the CPU end of its bus.
- Generates the free-running phi2 from the 2x clock.
- Turns a valid/ready request stream into phi2-aligned read/write bus cycles: address, RS0, CS1, R_W, write data.
- Captures read data and returns one response per request; used as the stimulus engine in sim and as the CPU stand-in on hardware.

Parameters:
- ADDR_W, 10, width of req_addr/bus_addr.
- DATA_W, 8, data width.
- RDY_TIMEOUT, 255, max wait-state phi2 periods before a read is aborted with error (RDY feature only).

Ports:
- phi2_2x  input  1  clock, 2x phi2 rate.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when valid & ready on a phi2_2x rising edge.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target address.
- req_rs0  input  1  RAM/IO select to the core.
- req_cs1  input  1  chip select to the core.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-clock response pulse.
- rsp_rdata  output  DATA_W  read data; holds its last value on writes.
- rsp_err  output  1  qualified by rsp_valid; read not driven or timed out.
- phi2  output  1  generated phase-2 clock to the core.
- bus_addr  output  ADDR_W  to core A.
- bus_rs0  output  1  to core RS0.
- bus_cs1  output  1  to core CS1.
- bus_r_w  output  1  to core we_n (1 = read).
- bus_do  output  DATA_W  to core DI.
- bus_di  input  DATA_W  from core DO.
- bus_oe  input  1  core OE; core is driving bus_di.
- rdy  input  1  wait-state request, active low stall (only with feature).

Behaviour:
- Reset (sync, wins over everything) gives these values: phi2=0, bus_addr=0, bus_rs0=0, bus_cs1=0, bus_r_w=1, bus_do=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE. An in-flight cycle is dropped with no response.
- phi2 toggles on every phi2_2x rising edge after reset and is free-running; the core timer depends on it. One bus cycle is one phi2 period: low phase then high phase, 2 clocks.
- req_ready = !rst & phi2==1 & (state==IDLE or state==HIGH with no wait pending). Acceptance happens only at the edge where phi2 goes 1->0.
- At acceptance, these are registered and held for the whole cycle: bus_addr, bus_rs0, bus_cs1, bus_r_w=!req_we, bus_do=req_wdata (writes).
- FSM states:
  - IDLE: bus_r_w=1, bus_cs1=0, addr/rs0/do hold their last values. On accept go to LOW.
  - LOW (phi2=0): go to HIGH.
  - HIGH (phi2=1): at the 1->0 edge the cycle completes. Reads capture bus_di into rsp_rdata and set rsp_err=!bus_oe. Writes set rsp_err=0. rsp_valid=1 for the next clock. Next state is LOW if a new request is accepted on the same edge, else IDLE.
- Back-to-back: one transaction per phi2 period, no bubble. The response for cycle N is valid during the LOW phase of cycle N+1.
- The response is never backpressured; the consumer must take rsp_valid when it pulses.
- req_* changes while not accepted are ignored. Bus outputs change only at the acceptance edge.

Optional Feature:
- Macro MCS6530_BUS_MASTER_RDY_EN.
- Defined, read cycles:
  - rdy is sampled at the end of HIGH. rdy=0 repeats LOW/HIGH with bus outputs held, no capture, req_ready=0, and the wait counter increments.
  - rdy=1 completes the cycle normally.
  - When the counter reaches RDY_TIMEOUT, the cycle completes with rsp_err=1 and rsp_rdata unchanged. The counter clears per transaction.
  - Writes ignore rdy (6502 semantics).
- Undefined: the rdy port remains but is ignored, the counter is not built, and every cycle is exactly 2 clocks.

Test Plan:
- Reset then free-run: rst high for 3 clocks, then low. phi2 is 0 on the first clock after release and toggles every clock. bus_r_w=1, req_ready first high when phi2=1.
- Write then read: write 0xA5 to addr 0x080 with rs0=0, then read 0x080. Core returns 0xA5 with bus_oe=1. Expect rsp_valid pulses 2 clocks apart, second with rsp_rdata=0xA5, rsp_err=0. bus_r_w=0 only during the write period.
- Back-to-back reads with req_valid held for 4 requests: exactly 4 rsp_valid pulses in 8 clocks, req_ready high every phi2=1 clock.
- Unmapped read with cs1=0 and bus_oe=0: rsp_valid with rsp_err=1, rsp_rdata=bus_di value.
- Reset mid-cycle: assert rst during HIGH of a read. No rsp_valid; all outputs take reset values the next clock.
- RDY_EN with rdy=0 for 3 phi2 periods: rsp after 8 clocks with data; with RDY_TIMEOUT=4 and rdy stuck at 0, rsp_err=1 after 5 periods.
